ps2_letter_capture: RTL
=======================

Name: ps2_letter_capture

Overview:
- Sits directly upstream of the 8-bit ASCII letter register in the Enigma/Bombe keyboard input path.
- Consumes the byte stream from the PS/2 receiver (scan code set 2) and tracks make, break and extended prefixes.
- Translates letter make codes to uppercase ASCII and issues a one-cycle load pulse so the register captures the letter.
- Suppresses typematic repeats of a held key.

Parameters:
- REPEAT_SUPPRESS, 1: 1 = ignore repeated make codes of the currently held key until its break code arrives; 0 = every make code emits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- scan_code  input  8  byte from the PS/2 receiver; valid only when scan_valid is high.
- scan_valid  input  1  one-cycle strobe; may be high on consecutive cycles.
- letter  output  8  ASCII of the last accepted letter ('A'..'Z' = 8'h41..8'h5A); feeds the letter register's data input.
- load  output  1  one-cycle pulse with letter valid; feeds the letter register's load input.
- key_held  output  1  high while a letter key is down (make seen, matching break not yet seen).

Behaviour:
- Reset (synchronous, wins over scan_valid in the same cycle):
  - state = IDLE, letter = 8'h41, load = 0, key_held = 0, held_code = 8'h00.
  - A reset mid-sequence (e.g. after F0) discards the pending prefix.
- FSM states: IDLE, BREAK (F0 seen), EXT (E0 seen), EXT_BREAK (E0 F0 seen). State only advances on cycles with scan_valid = 1.
- IDLE, byte F0: go to BREAK.
- IDLE, byte E0: go to EXT.
- IDLE, letter make code:
  - If REPEAT_SUPPRESS = 1, key_held = 1 and the code equals held_code: ignore it.
  - Otherwise, on the next edge: letter = ASCII, load = 1, held_code = code, key_held = 1.
- IDLE, any other byte: ignore and stay in IDLE.
- BREAK:
  - F0: stay in BREAK.
  - E0: go to EXT.
  - Any other byte: if key_held = 1 and the byte equals held_code, clear key_held. Then return to IDLE. Never emits.
- EXT:
  - F0: go to EXT_BREAK.
  - Any other byte: consume it and return to IDLE; no emit. Extended keys are never letters.
- EXT_BREAK: consume the next byte and return to IDLE; no emit; key_held unchanged.
- Latency: load is asserted exactly 1 cycle after the scan_valid cycle carrying the make code.
  - load is high for exactly one cycle and is 0 in every other cycle.
  - letter holds its value between loads.
- Rollover: a make code of a different letter while another key is held emits immediately and replaces held_code. A later break of the old key does not clear key_held.
- Back-to-back strobes: each byte is processed in its own cycle. Two letter makes on consecutive cycles give two consecutive load pulses, and letter updates each cycle.
- Mapping (set 2 code to ASCII): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.

Decomposition:
- Shared package/include:
  - CHAR_A = 8'h41.
  - SC_BREAK = 8'hF0, SC_EXT = 8'hE0.
  - 2-bit state encoding (IDLE = 0, BREAK = 1, EXT = 2, EXT_BREAK = 3).
- One sub-module, scancode_to_ascii: purely combinational, 8-bit code in, 8-bit ASCII plus is_letter flag out. It is reused by the display path.

Test Plan:
- Reset, then scan 1C -> load pulses 1 cycle later with letter = 8'h41; key_held = 1.
- Scan 1C, 1C, 1C (typematic), REPEAT_SUPPRESS = 1 -> exactly one load pulse. Repeat with REPEAT_SUPPRESS = 0 -> three pulses, letter = 8'h41 each.
- Scan 15, F0, 15, 15 -> loads for 'Q' (8'h51) twice; key_held goes 1, 0, then 1.
- Scan E0, 1C, E0, F0, 1C -> no load; state back in IDLE. A following 1A -> load with letter = 8'h5A.
- Back-to-back strobes 2D, 1B on consecutive cycles -> two consecutive load pulses, letter 8'h52 then 8'h53. Then F0, 2D -> key_held stays 1 (held_code = 1B).
- Scan F0, then assert reset on the next byte's cycle -> no load, letter = 8'h41, key_held = 0. A following 1C is treated as a make (load).

Source files
------------

// File: rtl/ps2_letter_capture_pkg.sv
// Shared constants and state encoding for the PS/2 letter capture path.
package ps2_letter_capture_pkg;

  localparam logic [7:0] CHAR_A   = 8'h41;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_e;

endpackage

// File: rtl/ps2_letter_capture_scancode_to_ascii.sv
// Combinational scan code set 2 to uppercase ASCII lookup; also used by the display path.
module scancode_to_ascii
  import ps2_letter_capture_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii,
  output logic       is_letter
);

  always_comb begin
    ascii     = CHAR_A;
    is_letter = 1'b1;
    case (code)
      8'h1C: ascii = 8'h41;
      8'h32: ascii = 8'h42;
      8'h21: ascii = 8'h43;
      8'h23: ascii = 8'h44;
      8'h24: ascii = 8'h45;
      8'h2B: ascii = 8'h46;
      8'h34: ascii = 8'h47;
      8'h33: ascii = 8'h48;
      8'h43: ascii = 8'h49;
      8'h3B: ascii = 8'h4A;
      8'h42: ascii = 8'h4B;
      8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D;
      8'h31: ascii = 8'h4E;
      8'h44: ascii = 8'h4F;
      8'h4D: ascii = 8'h50;
      8'h15: ascii = 8'h51;
      8'h2D: ascii = 8'h52;
      8'h1B: ascii = 8'h53;
      8'h2C: ascii = 8'h54;
      8'h3C: ascii = 8'h55;
      8'h2A: ascii = 8'h56;
      8'h1D: ascii = 8'h57;
      8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59;
      8'h1A: ascii = 8'h5A;
      default: is_letter = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_letter_capture.sv
// Tracks PS/2 make/break/extended prefixes and pulses load with the ASCII of each new letter make.
module ps2_letter_capture
  import ps2_letter_capture_pkg::*;
#(
  parameter bit REPEAT_SUPPRESS = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] letter,
  output logic       load,
  output logic       key_held
);

  state_e     state_q, state_d;
  logic [7:0] letter_q, letter_d;
  logic [7:0] held_q, held_d;
  logic       load_q, load_d;
  logic       key_held_q, key_held_d;
  logic [7:0] ascii;
  logic       is_letter;

  scancode_to_ascii u_map (
    .code      (scan_code),
    .ascii     (ascii),
    .is_letter (is_letter)
  );

  always_comb begin
    state_d    = state_q;
    letter_d   = letter_q;
    held_d     = held_q;
    load_d     = 1'b0;
    key_held_d = key_held_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (scan_code == SC_EXT) begin
            state_d = ST_EXT;
          end else if (is_letter &&
                       !(REPEAT_SUPPRESS && key_held_q && scan_code == held_q)) begin
            letter_d   = ascii;
            load_d     = 1'b1;
            held_d     = scan_code;
            key_held_d = 1'b1;
          end
        end
        ST_BREAK: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (scan_code == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            // Only the most recent letter's break releases the key; older keys are stale.
            if (key_held_q && scan_code == held_q) key_held_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        ST_EXT: begin
          state_d = (scan_code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      letter_q   <= CHAR_A;
      held_q     <= 8'h00;
      load_q     <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      letter_q   <= letter_d;
      held_q     <= held_d;
      load_q     <= load_d;
      key_held_q <= key_held_d;
    end
  end

  assign letter   = letter_q;
  assign load     = load_q;
  assign key_held = key_held_q;

endmodule
